// File: rtl/dfu_boot_ctrl.sv
// dfu_boot_ctrl
//   Boot-control and status-LED sequencer for the TinyDFU bootloader.
//   After reset release the DFU core is held in reset for USB_RESET_CYCLES.
//   The USB pull-up is then enabled and the auto-boot timer starts. DFU
//   activity or the user button cancels the auto boot. A DFU detach, or an
//   uncancelled timeout, raises a sticky boot_now. The status LEDs show a
//   bounce pattern, an idle blink (dfuIDLE) or all-lit (booting).
//
// Ports
//   clk             in   system clock
//   resetn          in   asynchronous active-low reset
//   dfu_state       in   [7:0] DFU state from the core (same clock domain)
//   dfu_detach      in   single-cycle detach pulse from the core
//   user_btn        in   asynchronous "stay in bootloader" button, active-high
//   usb_reset       out  reset to the DFU core, active-high
//   usb_pull_en     out  USB D+ pull-up enable
//   auto_boot_armed out  high while the auto-boot timer runs
//   boot_now        out  sticky request to boot the user image
//   led             out  [NUM_LEDS-1:0] status LEDs
module dfu_boot_ctrl #(
  parameter int CLK_HZ           = 12000000,
  parameter int BOOT_TIMEOUT_S   = 5,
  parameter int USB_RESET_CYCLES = 65535,
  parameter int NUM_LEDS         = 3,
  parameter int BLINK_BIT        = 21,
  parameter int SCAN_BIT         = 20,
  parameter bit LED_ACTIVE_LOW   = 1'b1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [7:0]          dfu_state,
  input  logic                dfu_detach,
  input  logic                user_btn,
  output logic                usb_reset,
  output logic                usb_pull_en,
  output logic                auto_boot_armed,
  output logic                boot_now,
  output logic [NUM_LEDS-1:0] led
);

  localparam int BOOT_CYCLES = CLK_HZ * BOOT_TIMEOUT_S;
  localparam int TMR_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam int RST_W = (USB_RESET_CYCLES > 1) ? $clog2(USB_RESET_CYCLES) : 1;
  localparam int CNT_W = ((BLINK_BIT > SCAN_BIT) ? BLINK_BIT : SCAN_BIT) + 1;
  localparam int POS_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(BOOT_CYCLES - 1);
  localparam logic [RST_W-1:0] RST_LOAD = RST_W'(USB_RESET_CYCLES - 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_LEDS - 1);

  typedef enum logic [1:0] {
    S_HOLD_RST = 2'd0,
    S_ARMED    = 2'd1,
    S_HELD     = 2'd2,
    S_BOOT     = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [RST_W-1:0]    r_rst_cnt;
  logic [TMR_W-1:0]    r_tmr;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_scan_d;
  logic [POS_W-1:0]    r_pos;
  logic                r_dir_up;
  logic                r_btn_s1;
  logic                r_btn_s2;
  logic                r_usb_reset;
  logic                r_pull_en;
  logic                r_armed;
  logic                r_boot;
  logic [NUM_LEDS-1:0] r_led;

  logic                w_cancel;
  logic                w_scan_rise;
  logic                w_usb_reset;
  logic                w_armed;
  logic                w_boot;
  logic [NUM_LEDS-1:0] w_pat;

  // Any DFU state beyond dfuIDLE means a host is talking to us.
  assign w_cancel    = (dfu_state > 8'd2) || r_btn_s2;
  assign w_scan_rise = r_cnt[SCAN_BIT] & ~r_scan_d;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_HOLD_RST;
    else         r_state <= w_next_state;
  end

  // Next-state logic; in ARMED the priority is detach > cancel > timeout
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_HOLD_RST: if (r_rst_cnt == '0) w_next_state = S_ARMED;
      S_ARMED: begin
        if (dfu_detach)        w_next_state = S_BOOT;
        else if (w_cancel)     w_next_state = S_HELD;
        else if (r_tmr == '0)  w_next_state = S_BOOT;
      end
      S_HELD:   if (dfu_detach) w_next_state = S_BOOT;
      S_BOOT:   w_next_state = S_BOOT;
      default:  w_next_state = S_HOLD_RST;
    endcase
  end

  // Output decode from the next state so the registered outputs change on
  // the same edge as the state itself.
  always_comb begin
    w_usb_reset = (w_next_state == S_HOLD_RST);
    w_armed     = (w_next_state == S_ARMED);
    w_boot      = (w_next_state == S_BOOT);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_usb_reset <= 1'b1;
      r_pull_en   <= 1'b0;
      r_armed     <= 1'b0;
      r_boot      <= 1'b0;
    end else begin
      r_usb_reset <= w_usb_reset;
      r_pull_en   <= ~w_usb_reset;
      r_armed     <= w_armed;
      r_boot      <= w_boot;
    end
  end

  // Reset-hold counter, boot timer, button synchroniser, free-running counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rst_cnt <= RST_LOAD;
      r_tmr     <= TMR_LOAD;
      r_btn_s1  <= 1'b0;
      r_btn_s2  <= 1'b0;
      r_cnt     <= '0;
      r_scan_d  <= 1'b0;
    end else begin
      r_btn_s1 <= user_btn;
      r_btn_s2 <= r_btn_s1;
      r_cnt    <= r_cnt + CNT_W'(1);
      r_scan_d <= r_cnt[SCAN_BIT];
      if (r_state == S_HOLD_RST && r_rst_cnt != '0)
        r_rst_cnt <= r_rst_cnt - RST_W'(1);
      // Timer is frozen outside ARMED and stops at zero rather than wrapping.
      if (r_state == S_HOLD_RST && w_next_state == S_ARMED)
        r_tmr <= TMR_LOAD;
      else if (r_state == S_ARMED && r_tmr != '0)
        r_tmr <= r_tmr - TMR_W'(1);
    end
  end

  // Bounce position: 0..N-1 then back down, reversing at each end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pos    <= '0;
      r_dir_up <= 1'b1;
    end else if (w_scan_rise && NUM_LEDS > 1) begin
      if (r_dir_up) begin
        if (r_pos == POS_LAST) begin
          r_pos    <= r_pos - POS_W'(1);
          r_dir_up <= 1'b0;
        end else begin
          r_pos <= r_pos + POS_W'(1);
        end
      end else begin
        if (r_pos == '0) begin
          r_pos    <= r_pos + POS_W'(1);
          r_dir_up <= 1'b1;
        end else begin
          r_pos <= r_pos - POS_W'(1);
        end
      end
    end
  end

  // Logical LED pattern (1 = lit)
  always_comb begin
    w_pat = '0;
    if (r_state == S_BOOT) begin
      w_pat = '1;
    end else if (dfu_state == 8'd2) begin
      w_pat[0] = r_cnt[BLINK_BIT];
    end else begin
      for (int i = 0; i < NUM_LEDS; i++)
        if (r_pos == POS_W'(i)) w_pat[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_led <= {NUM_LEDS{LED_ACTIVE_LOW}};
    else         r_led <= LED_ACTIVE_LOW ? ~w_pat : w_pat;
  end

  assign usb_reset       = r_usb_reset;
  assign usb_pull_en     = r_pull_en;
  assign auto_boot_armed = r_armed;
  assign boot_now        = r_boot;
  assign led             = r_led;

endmodule

// File: tb/tb_dfu_boot_ctrl.sv
// Directed testbench for dfu_boot_ctrl.
// Edge numbering: edge 0 is the first rising clock edge after resetn is
// released. "Value at edge s" is sampled on the falling edge just before
// rising edge s; inputs set there are sampled by the DUT at edge s.
module tb_dfu_boot_ctrl;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] dfu_state = 8'd0;
  logic       dfu_detach = 1'b0;
  logic       user_btn = 1'b0;
  logic       usb_reset, usb_pull_en, auto_boot_armed, boot_now;
  logic [3:0] led;
  logic [7:0] obs;

  int total = 0;
  int bad = 0;
  int pcount = 0;
  int base = 0;

  assign obs = {usb_reset, usb_pull_en, auto_boot_armed, boot_now, led};

  dfu_boot_ctrl #(
    .CLK_HZ(100), .BOOT_TIMEOUT_S(1), .USB_RESET_CYCLES(8), .NUM_LEDS(4),
    .BLINK_BIT(3), .SCAN_BIT(2), .LED_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .resetn(resetn), .dfu_state(dfu_state), .dfu_detach(dfu_detach),
    .user_btn(user_btn), .usb_reset(usb_reset), .usb_pull_en(usb_pull_en),
    .auto_boot_armed(auto_boot_armed), .boot_now(boot_now), .led(led)
  );

  always #5 clk = ~clk;
  always @(posedge clk) pcount <= pcount + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic go_to(input int s);
    while ((pcount - base) < s) @(negedge clk);
  endtask

  task automatic do_reset(input logic [7:0] ds);
    resetn     = 1'b0;
    dfu_detach = 1'b0;
    user_btn   = 1'b0;
    dfu_state  = ds;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    base   = pcount;
  endtask

  // Expected active-low LEDs for the bounce pattern at edge s.
  function automatic logic [3:0] bounce_led(input int s);
    int t, n, p;
    t = s - 1;
    n = (t <= 4) ? 0 : (t - 5) / 8 + 1;
    case (n % 6)
      0: p = 0;
      1: p = 1;
      2: p = 2;
      3: p = 3;
      4: p = 2;
      default: p = 1;
    endcase
    return ~(4'b0001 << p);
  endfunction

  // Expected active-low LEDs for the idle blink at edge s.
  function automatic logic [3:0] blink_led(input int s);
    logic [31:0] tv;
    tv = s - 1;
    return {3'b111, ~tv[3]};
  endfunction

  task automatic test_reset;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    if (obs !== 8'b1000_1111) begin bad++; $display("FAIL reset_state: got %b want %b", obs, 8'b1000_1111); end
    total++;
  endtask

  task automatic test_auto_boot;
    do_reset(8'd2);
    go_to(7);
    if (obs !== 8'b1000_1111) begin bad++; $display("FAIL ab_e7: got %b want %b", obs, 8'b1000_1111); end
    total++;
    go_to(8);
    if (obs !== 8'b0110_1111) begin bad++; $display("FAIL ab_e8: got %b want %b", obs, 8'b0110_1111); end
    total++;
    go_to(10);
    if (obs !== 8'b0110_1110) begin bad++; $display("FAIL ab_e10: got %b want %b", obs, 8'b0110_1110); end
    total++;
    go_to(107);
    if (obs !== 8'b0110_1110) begin bad++; $display("FAIL ab_e107: got %b want %b", obs, 8'b0110_1110); end
    total++;
    go_to(108);
    if (obs !== 8'b0101_1110) begin bad++; $display("FAIL ab_e108: got %b want %b", obs, 8'b0101_1110); end
    total++;
    go_to(109);
    if (obs !== 8'b0101_0000) begin bad++; $display("FAIL ab_e109: got %b want %b", obs, 8'b0101_0000); end
    total++;
    go_to(300);
    if (obs !== 8'b0101_0000) begin bad++; $display("FAIL ab_e300: got %b want %b", obs, 8'b0101_0000); end
    total++;
  endtask

  task automatic test_held;
    do_reset(8'd2);
    go_to(50);
    dfu_state = 8'd5;
    if (obs !== 8'b0110_1111) begin bad++; $display("FAIL held_e50: got %b want %b", obs, 8'b0110_1111); end
    total++;
    go_to(51);
    if (obs !== 8'b0100_1110) begin bad++; $display("FAIL held_e51: got %b want %b", obs, 8'b0100_1110); end
    total++;
    go_to(1100);
    if (obs[7:4] !== 4'b0100) begin bad++; $display("FAIL held_e1100: got %b want %b", obs[7:4], 4'b0100); end
    total++;
    dfu_detach = 1'b1;
    go_to(1101);
    dfu_detach = 1'b0;
    if (obs[7:4] !== 4'b0101) begin bad++; $display("FAIL held_detach: got %b want %b", obs[7:4], 4'b0101); end
    total++;
    go_to(1102);
    if (obs !== 8'b0101_0000) begin bad++; $display("FAIL held_boot_led: got %b want %b", obs, 8'b0101_0000); end
    total++;
  endtask

  task automatic test_detach;
    do_reset(8'd2);
    go_to(3);
    dfu_detach = 1'b1;
    go_to(4);
    dfu_detach = 1'b0;
    if (obs[7:4] !== 4'b1000) begin bad++; $display("FAIL det_holdrst: got %b want %b", obs[7:4], 4'b1000); end
    total++;
    go_to(107);
    dfu_state  = 8'd5;
    dfu_detach = 1'b1;
    if (obs[7:4] !== 4'b0110) begin bad++; $display("FAIL det_e107: got %b want %b", obs[7:4], 4'b0110); end
    total++;
    go_to(108);
    dfu_detach = 1'b0;
    if (obs[7:4] !== 4'b0101) begin bad++; $display("FAIL det_beats_cancel: got %b want %b", obs[7:4], 4'b0101); end
    total++;
  endtask

  task automatic test_cancel_at_timeout;
    do_reset(8'd2);
    go_to(107);
    dfu_state = 8'd5;
    go_to(108);
    if (obs[7:4] !== 4'b0100) begin bad++; $display("FAIL cancel_wins: got %b want %b", obs[7:4], 4'b0100); end
    total++;
    go_to(500);
    if (obs[7:4] !== 4'b0100) begin bad++; $display("FAIL cancel_stays: got %b want %b", obs[7:4], 4'b0100); end
    total++;
  endtask

  task automatic test_button;
    do_reset(8'd2);
    go_to(20);
    user_btn = 1'b1;
    go_to(22);
    if (obs[7:4] !== 4'b0110) begin bad++; $display("FAIL btn_e22: got %b want %b", obs[7:4], 4'b0110); end
    total++;
    go_to(23);
    user_btn = 1'b0;
    if (obs[7:4] !== 4'b0100) begin bad++; $display("FAIL btn_e23: got %b want %b", obs[7:4], 4'b0100); end
    total++;
    go_to(400);
    if (obs[7:4] !== 4'b0100) begin bad++; $display("FAIL btn_noboot: got %b want %b", obs[7:4], 4'b0100); end
    total++;
  endtask

  task automatic test_bounce_blink;
    do_reset(8'd3);
    for (int s = 1; s <= 60; s++) begin
      go_to(s);
      if (led !== bounce_led(s)) begin bad++; $display("FAIL bounce_e%0d: got %b want %b", s, led, bounce_led(s)); end
      total++;
    end
    dfu_state = 8'd2;
    for (int s = 61; s <= 99; s++) begin
      go_to(s);
      if (led !== blink_led(s)) begin bad++; $display("FAIL blink_e%0d: got %b want %b", s, led, blink_led(s)); end
      total++;
    end
    go_to(100);
    dfu_state = 8'd3;
    for (int s = 101; s <= 140; s++) begin
      go_to(s);
      if (led !== bounce_led(s)) begin bad++; $display("FAIL bounce2_e%0d: got %b want %b", s, led, bounce_led(s)); end
      total++;
    end
  endtask

  task automatic test_async_reset;
    do_reset(8'd2);
    go_to(50);
    #2;
    resetn = 1'b0;
    #1;
    if (obs !== 8'b1000_1111) begin bad++; $display("FAIL async_armed: got %b want %b", obs, 8'b1000_1111); end
    total++;
    @(negedge clk);
    resetn = 1'b1;
    base   = pcount;
    go_to(7);
    if (obs[7:4] !== 4'b1000) begin bad++; $display("FAIL async_re_e7: got %b want %b", obs[7:4], 4'b1000); end
    total++;
    go_to(8);
    if (obs[7:4] !== 4'b0110) begin bad++; $display("FAIL async_re_e8: got %b want %b", obs[7:4], 4'b0110); end
    total++;
    go_to(120);
    if (obs !== 8'b0101_0000) begin bad++; $display("FAIL async_boot: got %b want %b", obs, 8'b0101_0000); end
    total++;
    #2;
    resetn = 1'b0;
    #1;
    if (obs !== 8'b1000_1111) begin bad++; $display("FAIL async_inboot: got %b want %b", obs, 8'b1000_1111); end
    total++;
    @(negedge clk);
    resetn = 1'b1;
    base   = pcount;
    go_to(50);
    if (obs[7:4] !== 4'b0110) begin bad++; $display("FAIL async_restart: got %b want %b", obs[7:4], 4'b0110); end
    total++;
  endtask

  initial begin
    test_reset();
    test_auto_boot();
    test_held();
    test_detach();
    test_cancel_at_timeout();
    test_button();
    test_bounce_blink();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
